fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// Instruction fetch stage directly upstream of the instruction ROM: owns the program
// counter, drives the ROM address, captures the 16-bit word the ROM returns and hands
// it to decode via a valid/ready register. Handles branch redirect, halt and PC wrap.
// PARAMETERS
// ADDR_WIDTH   8       ROM address / PC width
// INSTR_WIDTH  16      instruction word width
// RESET_PC     8'h00   PC loaded on reset
// PORTS
// clock          in   1            rising-edge clock
// reset_n        in   1            asynchronous, active-low reset
// rom_address    out  ADDR_WIDTH   address to ROM; equals current PC
// rom_data       in   INSTR_WIDTH  combinational ROM read data for rom_address
// branch_valid   in   1            redirect request, sampled each edge
// branch_target  in   ADDR_WIDTH   redirect address
// halt           in   1            stop fetching, sampled each edge
// instr_valid    out  1            instr/instr_pc hold a fetched word
// instr_ready    in   1            decode accepts word this edge
// instr          out  INSTR_WIDTH  fetched instruction
// instr_pc       out  ADDR_WIDTH   address the instruction came from
// pc_wrapped     out  1            sticky: PC rolled over from all-ones to 0
// BEHAVIOUR
// - Reset (async on reset_n low): pc=RESET_PC, state=BOOT, instr_valid=0, instr=0,
//   instr_pc=0, pc_wrapped=0. rom_address=pc combinationally at all times.
// - States: BOOT -> RUN unconditionally after one clock; RUN -> HALTED when halt=1;
//   HALTED -> RUN when branch_valid=1 and halt=0; otherwise hold.
// - load = (state==RUN) && !branch_valid && (!instr_valid || instr_ready).
//   On load: instr<=rom_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
// - Consume without load (instr_valid && instr_ready && !load): instr_valid<=0.
// - Stall: instr_valid && !instr_ready -> instr, instr_pc, pc all held stable.
// - branch_valid (any state but BOOT): pc<=branch_target, instr_valid<=0 (flush,
//   even if instr_ready=0); no load that cycle. First target word valid next edge.
// - halt in RUN: no load that edge; pending word stays until consumed, then clears.
// - branch_valid && halt together: pc<=branch_target, flush, state=HALTED.
// - Branch/halt ignored in BOOT.
// - Wrap: pc+1 modulo 2^ADDR_WIDTH; load at pc=all-ones sets pc_wrapped=1, held
//   until reset. Branch to 0 does not set it.
// - Latency: first instr_valid at 2nd rising edge after reset_n rises (BOOT, then
//   load); throughput one word/clock while instr_ready=1.
// - Reset mid-operation: all state returns to reset values immediately, pending word
//   discarded.
// STRUCTURE
// - Shared header cpu_defs.vh: state encodings (BOOT/RUN/HALTED), ADDR_WIDTH,
//   INSTR_WIDTH, RESET_PC defaults; reused by decode and ROM.
// - One sub-module: program_counter (pc register, increment, load-target, wrap flag).
// - FSM and output register stay in fetch_unit.
// TESTING
// - ROM 0x00..0x03 = 1111,2222,3333,4444, ready=1 -> instr 1111@pc0 on edge 2, then one
//   word per clock with instr_pc 0,1,2,3.
// - ready=0 for 3 clocks while instr=2222 -> instr, instr_pc=1, rom_address=2 held; on
//   ready=1 next word 3333 loads same edge.
// - branch_valid=1 target=0x40 while instr_valid=1, ready=0 -> instr_valid=0 next edge,
//   then instr_pc=0x40 one edge later.
// - halt=1 at pc=5 -> no further loads, valid clears after consume; branch_valid to
//   0x10 -> RUN, instr_pc=0x10 next load.
// - branch to 0xFE, run 3 words -> instr_pc FE,FF,00; pc_wrapped=1 after FF load, stays 1.
// - reset_n low mid-stall -> instr_valid=0, rom_address=0x00, pc_wrapped=0 immediately.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared definitions for the fetch stage: default widths, reset
//               PC and the fetch FSM state encoding. Reused by decode and ROM.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    localparam int unsigned     C_ADDR_WIDTH  = 8;
    localparam int unsigned     C_INSTR_WIDTH = 16;
    localparam logic [7:0]      C_RESET_PC    = 8'h00;

    // Fetch sequencing: one BOOT cycle after reset, then RUN until halted.
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_program_counter.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_program_counter
// Description : Program counter for the fetch stage. Increments on a load,
//               takes the branch target on a redirect, and keeps a sticky flag
//               recording that an increment rolled over from all-ones to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit_program_counter #(
    parameter int unsigned            ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_inc,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_target,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic                  o_wrapped
);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_wrapped;

    // PC update: redirect wins over increment; only an increment can wrap,
    // so a branch straight to address zero leaves the flag untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_wrapped <= 1'b0;
        end else if (i_redirect) begin
            r_pc      <= i_target;
        end else if (i_inc) begin
            r_pc      <= r_pc + 1'b1;
            if (r_pc == {ADDR_WIDTH{1'b1}}) begin
                r_wrapped <= 1'b1;
            end
        end
    end

    assign o_pc      = r_pc;
    assign o_wrapped = r_wrapped;

endmodule : fetch_unit_program_counter
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Drives the ROM address from the PC,
//               captures the returned word into a valid/ready output register
//               for decode, and handles branch redirect, halt and PC wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH  = C_ADDR_WIDTH,
    parameter int unsigned            INSTR_WIDTH = C_INSTR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = ADDR_WIDTH'(C_RESET_PC)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    output logic [ADDR_WIDTH-1:0]  rom_address,
    input  logic [INSTR_WIDTH-1:0] rom_data,
    input  logic                   branch_valid,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    input  logic                   halt,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   pc_wrapped
);

    fetch_state_t           r_state;
    fetch_state_t           w_state_next;
    logic                   w_load;
    logic                   w_redirect;
    logic [ADDR_WIDTH-1:0]  w_pc;

    logic                   r_instr_valid;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [ADDR_WIDTH-1:0]  r_instr_pc;

    fetch_unit_program_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .clk        (clock),
        .rst_n      (reset_n),
        .i_inc      (w_load),
        .i_redirect (w_redirect),
        .i_target   (branch_target),
        .o_pc       (w_pc),
        .o_wrapped  (pc_wrapped)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus load/redirect decisions. Branch and halt are ignored
    // in BOOT; a halt suppresses the load on the very edge it is seen.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_redirect   = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                w_redirect = branch_valid;
                w_load     = !branch_valid && !halt
                             && (!r_instr_valid || instr_ready);
                if (halt) begin
                    w_state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                w_redirect = branch_valid;
                if (branch_valid && !halt) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

    // Output register: a redirect flushes even a stalled word, a load
    // replaces the word, a consume without a load empties the register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
        end else if (w_redirect) begin
            r_instr_valid <= 1'b0;
        end else if (w_load) begin
            r_instr_valid <= 1'b1;
            r_instr       <= rom_data;
            r_instr_pc    <= w_pc;
        end else if (r_instr_valid && instr_ready) begin
            r_instr_valid <= 1'b0;
        end
    end

    assign rom_address = w_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. Accepted words are
//               compared against a scoreboard queue of {pc, instr}; timing,
//               stall, flush, halt, wrap and reset behaviour checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic [7:0]  rom_address;
    logic [15:0] rom_data;
    logic        branch_valid;
    logic [7:0]  branch_target;
    logic        halt;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        pc_wrapped;

    int          checks;
    int          failures;
    logic [23:0] sb_q[$];

    fetch_unit dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .rom_address   (rom_address),
        .rom_data      (rom_data),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .halt          (halt),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .pc_wrapped    (pc_wrapped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] rom_fn(input logic [7:0] a);
        case (a)
            8'h00:   rom_fn = 16'h1111;
            8'h01:   rom_fn = 16'h2222;
            8'h02:   rom_fn = 16'h3333;
            8'h03:   rom_fn = 16'h4444;
            default: rom_fn = {a, ~a};
        endcase
    endfunction

    assign rom_data = rom_fn(rom_address);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] a);
        sb_q.push_back({a, rom_fn(a)});
    endtask

    // A word is taken by decode on the next edge when valid && ready and no
    // redirect is flushing it; inputs only change just after a rising edge.
    always @(negedge clock) begin
        if (reset_n && instr_valid && instr_ready && !branch_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_extra_word", 32'(sb_q.size()), 32'd1);
            end else begin
                chk("sb_word", {8'h00, instr_pc, instr}, {8'h00, sb_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        failures      = 0;
        reset_n       = 1'b0;
        branch_valid  = 1'b0;
        branch_target = 8'h00;
        halt          = 1'b0;
        instr_ready   = 1'b1;

        repeat (2) tick();
        chk("rst_valid",   32'(instr_valid), 32'd0);
        chk("rst_instr",   32'(instr),       32'd0);
        chk("rst_instr_pc",32'(instr_pc),    32'd0);
        chk("rst_rom_addr",32'(rom_address), 32'd0);
        chk("rst_wrapped", 32'(pc_wrapped),  32'd0);

        // Straight-line fetch with ready high, then a 3-cycle stall on 2222.
        push(8'h00);
        push(8'h01);
        reset_n = 1'b1;
        tick();
        chk("boot_no_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("first_valid", 32'(instr_valid), 32'd1);
        chk("first_instr", 32'(instr),       32'h1111);
        chk("first_pc",    32'(instr_pc),    32'h00);
        tick();
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_instr",    32'(instr),       32'h2222);
            chk("stall_pc",       32'(instr_pc),    32'h01);
            chk("stall_rom_addr", 32'(rom_address), 32'h02);
        end
        push(8'h02);
        instr_ready = 1'b1;
        tick();
        chk("unstall_instr", 32'(instr),    32'h3333);
        chk("unstall_pc",    32'(instr_pc), 32'h02);
        tick();
        chk("run_pc3", 32'(instr_pc), 32'h03);

        // Branch while a word is stalled: flush, then target word one edge later.
        instr_ready   = 1'b0;
        branch_valid  = 1'b1;
        branch_target = 8'h40;
        tick();
        chk("flush_valid",    32'(instr_valid), 32'd0);
        chk("flush_rom_addr", 32'(rom_address), 32'h40);
        branch_valid = 1'b0;
        tick();
        chk("target_valid", 32'(instr_valid), 32'd1);
        chk("target_pc",    32'(instr_pc),    32'h40);

        // Halt with word at pc 4 pending (pc=5).
        branch_valid  = 1'b1;
        branch_target = 8'h04;
        tick();
        branch_valid = 1'b0;
        tick();
        chk("pre_halt_pc", 32'(instr_pc),    32'h04);
        chk("pre_halt_ra", 32'(rom_address), 32'h05);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_hold_valid", 32'(instr_valid), 32'd1);
        chk("halt_hold_ra",    32'(rom_address), 32'h05);
        tick();
        chk("halted_hold_pc", 32'(instr_pc), 32'h04);
        push(8'h04);
        instr_ready = 1'b1;
        tick();
        chk("halted_consume", 32'(instr_valid), 32'd0);
        tick();
        chk("halted_no_load", 32'(instr_valid), 32'd0);
        chk("halted_ra",      32'(rom_address), 32'h05);
        branch_valid  = 1'b1;
        branch_target = 8'h10;
        tick();
        branch_valid = 1'b0;
        chk("resume_ra", 32'(rom_address), 32'h10);
        push(8'h10);
        tick();
        chk("resume_pc", 32'(instr_pc), 32'h10);
        tick();

        // Wrap through all-ones.
        branch_valid  = 1'b1;
        branch_target = 8'hFE;
        tick();
        branch_valid = 1'b0;
        chk("prewrap_flag", 32'(pc_wrapped), 32'd0);
        push(8'hFE);
        push(8'hFF);
        push(8'h00);
        tick();
        chk("wrap_pc_fe",   32'(instr_pc),   32'hFE);
        chk("wrap_flag_fe", 32'(pc_wrapped), 32'd0);
        tick();
        chk("wrap_pc_ff",   32'(instr_pc),   32'hFF);
        chk("wrap_flag_ff", 32'(pc_wrapped), 32'd1);
        tick();
        chk("wrap_pc_00",   32'(instr_pc),   32'h00);
        chk("wrap_flag_00", 32'(pc_wrapped), 32'd1);
        tick();
        instr_ready = 1'b0;
        chk("wrap_sticky", 32'(pc_wrapped), 32'd1);
        tick();

        // Asynchronous reset in the middle of a stall.
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid",   32'(instr_valid), 32'd0);
        chk("midrst_ra",      32'(rom_address), 32'h00);
        chk("midrst_wrapped", 32'(pc_wrapped),  32'd0);
        chk("midrst_sb_empty",32'(sb_q.size()), 32'd0);
        tick();

        // Branch during BOOT is ignored; branch to 0 does not set wrap.
        reset_n       = 1'b1;
        instr_ready   = 1'b1;
        branch_valid  = 1'b1;
        branch_target = 8'h80;
        tick();
        chk("boot_branch_ignored", 32'(rom_address), 32'h00);
        branch_target = 8'h00;
        tick();
        branch_valid = 1'b0;
        chk("br0_valid",   32'(instr_valid), 32'd0);
        chk("br0_wrapped", 32'(pc_wrapped),  32'd0);
        push(8'h00);
        tick();
        chk("br0_instr", 32'(instr), 32'h1111);
        tick();
        instr_ready = 1'b0;
        tick();
        chk("end_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
